// File: rtl/stack_ctrl_pkg.sv
// Shared types and defaults for the stack call controller and its depth tracker.
// Holds the FSM state encoding, request op codes and the default geometry.
package stack_ctrl_pkg;

  localparam int unsigned DATA_W_DEF  = 19;
  localparam int unsigned DEPTH_DEF   = 32;
  localparam int unsigned DEPTH_W_DEF = $clog2(DEPTH_DEF) + 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_P_SETUP  = 3'd2,
    ST_P_STROBE = 3'd3,
    ST_Q_STROBE = 3'd4,
    ST_Q_CAPT   = 3'd5,
    ST_C_STROBE = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_ILL  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic [1:0] raw);
    return op_e'(raw);
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Depth counter mirroring the external stack pointer, with full/empty flags.
// STACK_OVF_TRAP_EN: when defined, push at full / pop at empty is blocked instead of wrapping.
module stack_depth_tracker
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               clr_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               push_blocked_o,
  output logic               pop_blocked_o
);

  localparam logic [DEPTH_W-1:0] FULL_C = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] WRAP_C = DEPTH_W'(DEPTH - 1);
  localparam logic [DEPTH_W-1:0] ONE_C  = DEPTH_W'(1);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               full_q, empty_q;

  always_comb begin
    depth_d = depth_q;
    if (clr_i) begin
      depth_d = '0;
    end else if (inc_i) begin
      if (depth_q == FULL_C) begin
`ifdef STACK_OVF_TRAP_EN
        depth_d = depth_q;
`else
        depth_d = ONE_C;
`endif
      end else begin
        depth_d = depth_q + ONE_C;
      end
    end else if (dec_i) begin
      if (depth_q == '0) begin
`ifdef STACK_OVF_TRAP_EN
        depth_d = depth_q;
`else
        depth_d = WRAP_C;
`endif
      end else begin
        depth_d = depth_q - ONE_C;
      end
    end else begin
      depth_d = depth_q;
    end
  end

  // Flags are registered from the next depth so they line up with depth_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      depth_q <= depth_d;
      full_q  <= (depth_d == FULL_C);
      empty_q <= (depth_d == '0);
    end
  end

  always_comb begin
`ifdef STACK_OVF_TRAP_EN
    push_blocked_o = full_q;
    pop_blocked_o  = empty_q;
`else
    push_blocked_o = 1'b0;
    pop_blocked_o  = 1'b0;
`endif
  end

  assign depth_o = depth_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/stack_call_ctrl.sv
// Initiator for the edge-triggered LIFO stack: turns CALL/RET/CLR into registered strobes.
// STACK_OVF_TRAP_EN (see stack_depth_tracker) turns overflow/underflow into error responses.
module stack_call_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  input  logic [1:0]         req_op_i,
  input  logic [DATA_W-1:0]  pc_in_i,
  output logic               req_ready_o,
  output logic               rsp_valid_o,
  output logic [DATA_W-1:0]  rsp_addr_o,
  output logic               rsp_err_o,
  output logic               stk_push_o,
  output logic               stk_pop_o,
  output logic               stk_clr_o,
  output logic [DATA_W-1:0]  stk_din_o,
  input  logic [DATA_W-1:0]  stk_dout_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);

  state_e              state_q;
  logic                trap_q;
  logic                req_ready_q, rsp_valid_q, rsp_err_q;
  logic                stk_push_q, stk_pop_q, stk_clr_q;
  logic [DATA_W-1:0]   stk_din_q, rsp_addr_q;

  logic                accept_s;
  op_e                 op_s;
  logic                trk_inc_s, trk_dec_s, trk_clr_s;
  logic                push_blocked_s, pop_blocked_s;

  assign op_s     = decode_op(req_op_i);
  assign accept_s = (state_q == ST_IDLE) && req_ready_q && req_valid_i;

  // Depth moves on the same edge that raises the matching strobe.
  always_comb begin
    trk_inc_s = 1'b0;
    trk_dec_s = 1'b0;
    trk_clr_s = 1'b0;
    if (state_q == ST_INIT) begin
      trk_clr_s = 1'b1;
    end else if (state_q == ST_P_SETUP) begin
      trk_inc_s = !trap_q;
    end else if (accept_s) begin
      trk_dec_s = (op_s == OP_RET) && !pop_blocked_s;
      trk_clr_s = (op_s == OP_CLR);
    end else begin
      trk_inc_s = 1'b0;
    end
  end

  stack_depth_tracker #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_depth (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .inc_i          (trk_inc_s),
    .dec_i          (trk_dec_s),
    .clr_i          (trk_clr_s),
    .depth_o        (depth_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .push_blocked_o (push_blocked_s),
    .pop_blocked_o  (pop_blocked_s)
  );

  // Sequencer: every stk_* and rsp_* output is a flop written here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT;
      trap_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_clr_q   <= 1'b0;
      stk_din_q   <= '0;
      rsp_addr_q  <= '0;
    end else begin
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_clr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_INIT: begin
          // First cycle raises the clear strobe, second cycle hands over to IDLE.
          if (!stk_clr_q) begin
            stk_clr_q <= 1'b1;
          end else begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            case (op_s)
              OP_CALL: begin
                trap_q      <= push_blocked_s;
                if (!push_blocked_s) stk_din_q <= pc_in_i;
                state_q     <= ST_P_SETUP;
                req_ready_q <= 1'b0;
              end
              OP_RET: begin
                trap_q      <= pop_blocked_s;
                stk_pop_q   <= !pop_blocked_s;
                state_q     <= ST_Q_STROBE;
                req_ready_q <= 1'b0;
              end
              OP_CLR: begin
                stk_clr_q   <= 1'b1;
                state_q     <= ST_C_STROBE;
                req_ready_q <= 1'b0;
              end
              OP_ILL: begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end
              default: begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_P_SETUP: begin
          stk_push_q <= !trap_q;
          state_q    <= ST_P_STROBE;
        end
        ST_P_STROBE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= trap_q;
        end
        ST_Q_STROBE: begin
          state_q <= ST_Q_CAPT;
        end
        ST_Q_CAPT: begin
          rsp_addr_q  <= stk_dout_i;
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= trap_q;
        end
        ST_C_STROBE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign stk_push_o  = stk_push_q;
  assign stk_pop_o   = stk_pop_q;
  assign stk_clr_o   = stk_clr_q;
  assign stk_din_o   = stk_din_q;

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Bench for stack_call_ctrl: directed scenarios plus random requests against a queue-based model.
// Expectations follow the STACK_OVF_TRAP_EN setting of the build.
module tb_stack_call_ctrl;

  localparam logic [1:0] C_ILL  = 2'b00;
  localparam logic [1:0] C_CALL = 2'b01;
  localparam logic [1:0] C_RET  = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [18:0] pc_in = 19'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [18:0] rsp_addr, stk_din;
  logic [18:0] stk_dout = 19'h0;
  logic        stk_push, stk_pop, stk_clr;
  logic [5:0]  depth;
  logic        full, empty;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_depth = 0;
  logic [18:0] mq[$];
  bit          addr_ok = 1'b1;
  logic [18:0] last_din = 19'h0;

  // Environment: behavioural 32-entry stack reacting to the strobes
  logic [18:0] mem [32];
  logic [4:0]  sp = 5'd0;

  always #5 clk = ~clk;

  stack_call_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .pc_in_i     (pc_in),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_addr_o  (rsp_addr),
    .rsp_err_o   (rsp_err),
    .stk_push_o  (stk_push),
    .stk_pop_o   (stk_pop),
    .stk_clr_o   (stk_clr),
    .stk_din_o   (stk_din),
    .stk_dout_i  (stk_dout),
    .depth_o     (depth),
    .full_o      (full),
    .empty_o     (empty)
  );

  always @(posedge clk) begin
    if (stk_clr) begin
      sp <= 5'd0;
    end else if (stk_push) begin
      mem[sp] <= stk_din;
      sp      <= sp + 5'd1;
    end else if (stk_pop) begin
      stk_dout <= mem[sp - 5'd1];
      sp       <= sp - 5'd1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check quiet outputs, release and check the single INIT clear pulse.
  task automatic do_reset(input bit hold_call, input logic [18:0] hold_pc);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_push", stk_push, 0);
      chk("rst_clr", stk_clr, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_depth", depth, 0);
      chk("rst_empty", empty, 1);
      step();
    end
    rst_n = 1'b1;
    if (hold_call) begin
      req_valid = 1'b1;
      req_op    = C_CALL;
      pc_in     = hold_pc;
    end
    chk("init0_clr", stk_clr, 0);
    chk("init0_ready", req_ready, 0);
    step();
    chk("init1_clr", stk_clr, 1);
    chk("init1_ready", req_ready, 0);
    chk("init1_push", stk_push, 0);
    m_depth = 0;
    mq.delete();
    addr_ok = 1'b1;
    last_din = 19'h0;
    step();
    chk("init2_clr", stk_clr, 0);
    chk("init2_ready", req_ready, 1);
    chk("init2_depth", depth, 0);
    chk("init2_empty", empty, 1);
    chk("init2_rsp", rsp_valid, 0);
  endtask

  // Issue one request, follow it cycle by cycle and compare with the model.
  task automatic run_req(input logic [1:0] op, input logic [18:0] pc);
    int          lat;
    int          wait_n;
    bit          trap;
    bit          addr_chk;
    logic [18:0] exp_addr;
    req_valid = 1'b1;
    req_op    = op;
    pc_in     = pc;
    wait_n    = 0;
    while (req_ready !== 1'b1 && wait_n < 20) begin
      step();
      wait_n++;
    end
    if (req_ready !== 1'b1) begin
      chk("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    trap = 1'b0;
`ifdef STACK_OVF_TRAP_EN
    trap = (op == C_CALL && m_depth == 32) || (op == C_RET && m_depth == 0);
`endif
    lat = (op == C_CALL || op == C_RET) ? 3 : (op == C_CLR) ? 2 : 1;
    addr_chk = 1'b0;
    exp_addr = 19'h0;
    if (op == C_CALL && !trap) begin
      last_din = pc;
      if (m_depth == 32) begin
        m_depth = 1;
        addr_ok = 1'b0;
      end else begin
        m_depth++;
      end
      mq.push_back(pc);
    end else if (op == C_RET && !trap) begin
      if (m_depth == 0) begin
        m_depth = 31;
        addr_ok = 1'b0;
      end else begin
        m_depth--;
        if (addr_ok && mq.size() > 0) begin
          exp_addr = mq.pop_back();
          addr_chk = 1'b1;
        end
      end
    end else if (op == C_CLR) begin
      m_depth = 0;
      mq.delete();
      addr_ok = 1'b1;
    end
    step();
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    pc_in     = 19'($urandom);
    for (int k = 1; k <= lat; k++) begin
      chk("push", stk_push, (op == C_CALL && k == 2 && !trap));
      chk("pop", stk_pop, (op == C_RET && k == 1 && !trap));
      chk("clr", stk_clr, (op == C_CLR && k == 1));
      chk("rsp_valid", rsp_valid, (k == lat));
      chk("ready", req_ready, (k == lat));
      if (op == C_CALL && k == 1 && !trap) chk("din_setup", stk_din, pc);
      if (k < lat) step();
    end
    chk("rsp_err", rsp_err, ((op == C_ILL) || trap));
    chk("depth", depth, m_depth);
    chk("full", full, (m_depth == 32));
    chk("empty", empty, (m_depth == 0));
    chk("din_hold", stk_din, last_din);
    if (addr_chk) chk("rsp_addr", rsp_addr, exp_addr);
    step();
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    logic [1:0] rop;
    int         r;
    step();
    do_reset(1'b0, 19'h0);

    run_req(C_CALL, 19'h12345);

    run_req(C_CLR, 19'h0);
    run_req(C_CALL, 19'h00AAA);
    run_req(C_CALL, 19'h7FFFF);
    run_req(C_RET, 19'h0);
    run_req(C_RET, 19'h0);

    run_req(C_CLR, 19'h0);
    for (int i = 0; i < 32; i++) run_req(C_CALL, 19'($urandom));
    run_req(C_CALL, 19'h55555);

    run_req(C_CLR, 19'h0);
    run_req(C_RET, 19'h0);
    run_req(C_CLR, 19'h0);
    run_req(C_ILL, 19'h0);

    for (int i = 0; i < 5; i++) run_req(C_CALL, 19'($urandom));
    run_req(C_CLR, 19'h0);

    // Abort a CALL in P_SETUP, then hold a CALL through INIT after release.
    req_valid = 1'b1;
    req_op    = C_CALL;
    pc_in     = 19'h3C3C3;
    step();
    req_valid = 1'b0;
    do_reset(1'b1, 19'h2468A);
    run_req(C_CALL, 19'h2468A);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      rop = (r < 40) ? C_CALL : (r < 78) ? C_RET : (r < 90) ? C_CLR : C_ILL;
      run_req(rop, 19'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
